// File: rtl/counter_sampler.sv
// Avalon-MM read master that periodically samples a 64-bit counter slave with a
// rollover-safe hi/lo/hi read sequence and publishes the sample plus its delta.
module counter_sampler #(
    parameter int         SAMPLE_PERIOD = 1000,
    parameter int         READ_LATENCY  = 1,
    parameter logic [3:0] ADDR_LO       = 4'h0,
    parameter logic [3:0] ADDR_HI       = 4'h4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [3:0]  m_address,
    output logic        m_read,
    input  logic        m_waitrequest,
    input  logic [31:0] m_readdata,
    output logic [63:0] sample,
    output logic [63:0] delta,
    output logic        sample_valid,
    output logic        overrun,
    output logic [7:0]  retries
);

    localparam int              TW         = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam logic [TW-1:0]   TIMER_LAST = TW'(SAMPLE_PERIOD - 1);
    localparam logic [1:0]      LAT_LAST   = 2'(READ_LATENCY - 1);

    typedef enum logic [2:0] {
        IDLE,
        RD_HI1,
        W_HI1,
        RD_LO,
        W_LO,
        RD_HI2,
        W_HI2,
        DONE
    } state_t;

    state_t        state_q,     state_d;
    logic [TW-1:0] timer_q,     timer_d;
    logic          tick_q,      tick_d;
    logic          m_read_q,    m_read_d;
    logic [3:0]    m_address_q, m_address_d;
    logic [1:0]    lat_q,       lat_d;
    logic [31:0]   h1_q,        h1_d;
    logic [31:0]   lo_q,        lo_d;
    logic [63:0]   prev_q,      prev_d;
    logic [63:0]   sample_q,    sample_d;
    logic [63:0]   delta_q,     delta_d;
    logic          overrun_q,   overrun_d;
    logic [7:0]    retries_q,   retries_d;
    logic          first_q,     first_d;

    logic          accept;
    logic          lat_done;
    logic [63:0]   coherent;

    assign accept   = m_read_q && !m_waitrequest;
    assign lat_done = (lat_q == LAT_LAST);
    assign coherent = {h1_q, lo_q};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            timer_q     <= '0;
            tick_q      <= 1'b0;
            m_read_q    <= 1'b0;
            m_address_q <= ADDR_HI;
            lat_q       <= '0;
            h1_q        <= '0;
            lo_q        <= '0;
            prev_q      <= '0;
            sample_q    <= '0;
            delta_q     <= '0;
            overrun_q   <= 1'b0;
            retries_q   <= '0;
            first_q     <= 1'b1;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            tick_q      <= tick_d;
            m_read_q    <= m_read_d;
            m_address_q <= m_address_d;
            lat_q       <= lat_d;
            h1_q        <= h1_d;
            lo_q        <= lo_d;
            prev_q      <= prev_d;
            sample_q    <= sample_d;
            delta_q     <= delta_d;
            overrun_q   <= overrun_d;
            retries_q   <= retries_d;
            first_q     <= first_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        tick_d      = 1'b0;
        m_read_d    = m_read_q;
        m_address_d = m_address_q;
        lat_d       = lat_q;
        h1_d        = h1_q;
        lo_d        = lo_q;
        prev_d      = prev_q;
        sample_d    = sample_q;
        delta_d     = delta_q;
        overrun_d   = overrun_q;
        retries_d   = retries_q;
        first_d     = first_q;

        // The tick is registered so it lands on the cycle the timer reads 0 again.
        if (!enable) begin
            timer_d = '0;
        end else if (timer_q == TIMER_LAST) begin
            timer_d = '0;
            tick_d  = 1'b1;
        end else begin
            timer_d = timer_q + 1'b1;
        end

        if (tick_q && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (tick_q) begin
                    state_d     = RD_HI1;
                    m_read_d    = 1'b1;
                    m_address_d = ADDR_HI;
                end
            end
            // Entering a read state from a wait state leaves m_read low for one
            // address-setup cycle; it then stays high until accepted.
            RD_HI1, RD_LO, RD_HI2: begin
                if (accept) begin
                    m_read_d = 1'b0;
                    lat_d    = '0;
                    case (state_q)
                        RD_HI1:  state_d = W_HI1;
                        RD_LO:   state_d = W_LO;
                        default: state_d = W_HI2;
                    endcase
                end else begin
                    m_read_d = 1'b1;
                end
            end
            W_HI1: begin
                if (lat_done) begin
                    h1_d        = m_readdata;
                    state_d     = RD_LO;
                    m_address_d = ADDR_LO;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            W_LO: begin
                if (lat_done) begin
                    lo_d        = m_readdata;
                    state_d     = RD_HI2;
                    m_address_d = ADDR_HI;
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            W_HI2: begin
                if (lat_done) begin
                    if (m_readdata == h1_q) begin
                        // Publish on entry to DONE so sample/delta are already
                        // valid during the sample_valid cycle.
                        state_d  = DONE;
                        sample_d = coherent;
                        delta_d  = first_q ? 64'd0 : (coherent - prev_q);
                        prev_d   = coherent;
                        first_d  = 1'b0;
                    end else begin
                        if (retries_q != 8'hFF) begin
                            retries_d = retries_q + 8'd1;
                        end
                        h1_d        = m_readdata;
                        state_d     = RD_LO;
                        m_address_d = ADDR_LO;
                    end
                end else begin
                    lat_d = lat_q + 2'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign m_address    = m_address_q;
    assign m_read       = m_read_q;
    assign sample       = sample_q;
    assign delta        = delta_q;
    assign sample_valid = (state_q == DONE);
    assign overrun      = overrun_q;
    assign retries      = retries_q;

endmodule

// File: tb/tb_counter_sampler.sv
// Directed bench for counter_sampler: static/incrementing counter, scripted
// rollover race, stalled bus, tick overrun and asynchronous reset mid-read.
module tb_counter_sampler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [3:0]  m_address;
    logic        m_read;
    logic        m_waitrequest;
    logic [31:0] m_readdata;
    logic [63:0] sample;
    logic [63:0] delta;
    logic        sample_valid;
    logic        overrun;
    logic [7:0]  retries;

    int checks = 0;
    int errors = 0;

    // Slave model controls
    logic [63:0] base = 64'd0;
    logic        inc  = 1'b0;
    logic [63:0] cyc  = 64'd0;
    logic [63:0] cyc0 = 64'd0;
    logic [63:0] cnt_now;
    logic [31:0] script_mem [0:7];
    int          script_start = 0;
    int          script_len   = 0;
    int          rd_count     = 0;
    int          stall_cfg    = 0;
    int          stall_cnt    = 0;
    logic        force_wait   = 1'b0;
    logic [31:0] rdata        = 32'd0;

    // Bus monitor state
    logic [3:0]  acc_addr [0:255];
    int          acc_cnt    = 0;
    int          stab_viol  = 0;
    logic        prev_stall = 1'b0;
    logic [3:0]  prev_addr  = 4'd0;

    counter_sampler #(
        .SAMPLE_PERIOD(16),
        .READ_LATENCY (1),
        .ADDR_LO      (4'h0),
        .ADDR_HI      (4'h4)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .m_address    (m_address),
        .m_read       (m_read),
        .m_waitrequest(m_waitrequest),
        .m_readdata   (m_readdata),
        .sample       (sample),
        .delta        (delta),
        .sample_valid (sample_valid),
        .overrun      (overrun),
        .retries      (retries)
    );

    always #5 clk = ~clk;

    assign cnt_now       = base + (inc ? (cyc - cyc0) : 64'd0);
    assign m_waitrequest = force_wait | (m_read & (stall_cnt < stall_cfg));
    assign m_readdata    = rdata;

    // Counter slave, one cycle of read latency
    always @(posedge clk) begin
        cyc <= cyc + 64'd1;
        if (m_read && !m_waitrequest) begin
            rd_count  <= rd_count + 1;
            stall_cnt <= 0;
            if (rd_count - script_start < script_len)
                rdata <= script_mem[3'(rd_count - script_start)];
            else if (m_address == 4'h4)
                rdata <= cnt_now[63:32];
            else
                rdata <= cnt_now[31:0];
        end else if (m_read && m_waitrequest) begin
            stall_cnt <= stall_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (m_read && !m_waitrequest) begin
            acc_addr[acc_cnt[7:0]] <= m_address;
            acc_cnt <= acc_cnt + 1;
        end
        if (prev_stall && (!m_read || m_address != prev_addr))
            stab_viol <= stab_viol + 1;
        prev_stall <= m_read && m_waitrequest;
        prev_addr  <= m_address;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cycles (counted from the caller's current cycle) until sample_valid is seen.
    task automatic wait_valid(input string tag, input int max, output int n);
        bit ok;
        ok = 1'b0;
        n  = 0;
        while (n < max && !ok) begin
            @(posedge clk);
            #1;
            n++;
            if (sample_valid) ok = 1'b1;
        end
        if (ok) begin
            $display("t=%0t %s: sample_valid sample=%h delta=%h retries=%0d overrun=%0d",
                     $time, tag, sample, delta, retries, overrun);
        end else begin
            checks++;
            errors++;
            $error("FAIL %s timeout: observed no sample_valid in %0d cycles, required one", tag, max);
        end
    endtask

    task automatic chk_addrs(input string tag, input int first, input int cnt);
        logic [3:0] exp;
        for (int i = 0; i < cnt; i++) begin
            exp = (i % 2 == 0) ? 4'h4 : 4'h0;
            chk($sformatf("%s_addr%0d", tag, i), 64'(acc_addr[8'(first + i)]), 64'(exp));
        end
    endtask

    initial begin
        int n;
        int ab;
        int pulses;
        logic [63:0] seen_sample;
        logic [63:0] seen_delta;
        bit found;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_sample", sample, 64'd0);
        chk("rst_delta", delta, 64'd0);
        chk("rst_valid", 64'(sample_valid), 64'd0);
        chk("rst_overrun", 64'(overrun), 64'd0);
        chk("rst_retries", 64'(retries), 64'd0);
        chk("rst_read", 64'(m_read), 64'd0);
        chk("rst_addr", 64'(m_address), 64'h4);

        // Static count: first tick 16 cycles after enable, sample_valid 9 later
        base   = 64'h100;
        ab     = acc_cnt;
        reset  = 1'b0;
        enable = 1'b1;
        wait_valid("static", 40, n);
        chk("static_cycles", 64'(n), 64'd25);
        chk("static_sample", sample, 64'h100);
        chk("static_delta", delta, 64'd0);
        chk("static_retries", 64'(retries), 64'd0);
        chk_addrs("static", ab, 3);

        // Incrementing count, reads at cycles 36 and 52 relative to enable
        base = 64'h500;
        inc  = 1'b1;
        cyc0 = cyc;
        wait_valid("inc1", 40, n);
        chk("inc1_cycles", 64'(n), 64'd16);
        chk("inc1_sample", sample, 64'h50B);
        chk("inc1_delta", delta, 64'h40B);
        wait_valid("inc2", 40, n);
        chk("inc2_cycles", 64'(n), 64'd16);
        chk("inc2_sample", sample, 64'h51B);
        chk("inc2_delta", delta, 64'h10);
        chk("inc2_retries", 64'(retries), 64'd0);

        // Rollover race: h1=0, lo=FFFFFFFF, h2=1 -> retry lo=3, h2=1
        script_mem[0] = 32'h0000_0000;
        script_mem[1] = 32'hFFFF_FFFF;
        script_mem[2] = 32'h0000_0001;
        script_mem[3] = 32'h0000_0003;
        script_mem[4] = 32'h0000_0001;
        script_start  = rd_count;
        script_len    = 5;
        inc           = 1'b0;
        base          = 64'h1_0000_0003;
        ab            = acc_cnt;
        wait_valid("race", 40, n);
        chk("race_cycles", 64'(n), 64'd22);
        chk("race_sample", sample, 64'h1_0000_0003);
        chk("race_delta", delta, 64'hFFFF_FAE8);
        chk("race_retries", 64'(retries), 64'd1);
        chk_addrs("race", ab, 5);
        wait_valid("post_race", 40, n);
        chk("post_race_cycles", 64'(n), 64'd10);
        chk("post_race_delta", delta, 64'd0);
        chk("post_race_overrun", 64'(overrun), 64'd0);

        // Three-cycle stall on every read: 9 cycles later, tick at 32 overruns
        script_len = 0;
        base       = 64'h1234_5678_9ABC_DEF0;
        stall_cfg  = 3;
        reset      = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ab    = acc_cnt;
        wait_valid("stall", 60, n);
        chk("stall_cycles", 64'(n), 64'd34);
        chk("stall_sample", sample, 64'h1234_5678_9ABC_DEF0);
        chk("stall_delta", delta, 64'd0);
        chk("stall_overrun", 64'(overrun), 64'd1);
        chk("stall_stable", 64'(stab_viol), 64'd0);
        chk_addrs("stall", ab, 3);

        // Waitrequest stuck for 40 cycles on the first read
        stall_cfg  = 0;
        force_wait = 1'b1;
        reset      = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (m_read) found = 1'b1;
        end
        chk("stuck_read_seen", 64'(found), 64'd1);
        chk("stuck_overrun_pre", 64'(overrun), 64'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("stuck_overrun", 64'(overrun), 64'd1);
        force_wait  = 1'b0;
        enable      = 1'b0;
        pulses      = 0;
        seen_sample = 64'd0;
        seen_delta  = 64'hDEAD;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (sample_valid) begin
                pulses++;
                seen_sample = sample;
                seen_delta  = delta;
                $display("t=%0t stuck: sample_valid sample=%h delta=%h", $time, sample, delta);
            end
        end
        chk("stuck_pulses", 64'(pulses), 64'd1);
        chk("stuck_sample", seen_sample, 64'h1234_5678_9ABC_DEF0);
        chk("stuck_delta", seen_delta, 64'd0);
        chk("stuck_overrun_hold", 64'(overrun), 64'd1);
        chk("stuck_stable", 64'(stab_viol), 64'd0);

        // Asynchronous reset while waiting for the low word
        base   = 64'h100;
        enable = 1'b1;
        reset  = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_valid("pre_rst", 40, n);
        chk("pre_rst_sample", sample, 64'h100);
        base  = 64'h900;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk);
            #1;
            if (m_read && !m_waitrequest && m_address == 4'h0) found = 1'b1;
        end
        chk("lo_accept_seen", 64'(found), 64'd1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_sample", sample, 64'd0);
        chk("arst_delta", delta, 64'd0);
        chk("arst_valid", 64'(sample_valid), 64'd0);
        chk("arst_overrun", 64'(overrun), 64'd0);
        chk("arst_retries", 64'(retries), 64'd0);
        chk("arst_read", 64'(m_read), 64'd0);
        chk("arst_addr", 64'(m_address), 64'h4);
        @(posedge clk);
        #1;
        base  = 64'h2000;
        reset = 1'b0;
        wait_valid("post_rst", 40, n);
        chk("post_rst_cycles", 64'(n), 64'd25);
        chk("post_rst_sample", sample, 64'h2000);
        chk("post_rst_delta", delta, 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
